elevator_call_scheduler: RTL and testbench
==========================================

# elevator_call_scheduler

Request-side companion of `elevator_controller`: it sits between the floor call buttons and the controller and drives the controller's `req_floor` and `timer_expired` inputs. It latches button presses for three floors and selects one target floor at a time using a direction-preferred sweep. It observes the controller's `current_floor`, `motor_dir` and `door` outputs to clear served calls and to time the door-open interval. The top level instantiates one scheduler per controller.

## Interface
- `DOOR_CYCLES`, default 4: number of consecutive `door`-high cycles before `timer_expired` pulses. Legal range 1..255.

- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `call_btn` input 3: call buttons, bit i = floor i. Level-sensitive, any width of pulse.
- `current_floor` input 2: floor reported by the controller, 0..2. Value 3 is invalid.
- `motor_dir` input 2: controller motor state. 00 = stopped, 01 = up, 10 = down, 11 = invalid (treated as stopped).
- `door` input 1: controller door state, 1 = open.
- `req_floor` output 3: one-hot target floor for the controller. Registered; always exactly one bit set.
- `timer_expired` output 1: one-cycle door-timeout pulse. Registered.
- `pending` output 3: latched outstanding calls, used for the button lamps.
- `busy` output 1: high when `pending` != 000 or the FSM is in DOOR_WAIT.

## Operation
- **Reset:** forces the following values on the next edge.
  - `pending` = 000, `req_floor` = 001, `timer_expired` = 0, `busy` = 0.
  - State = IDLE, direction preference = UP, door counter = 0.
- **Call latching:** each cycle `pending` <= `pending` | `call_btn`, minus the clear term below.
  - Exception: a press for floor f is dropped when `door` = 1 and `current_floor` = f in that cycle.
- **Clearing:** in DOOR_WAIT, when `door` = 1, the bit for `current_floor` is cleared.
  - Clear takes priority over a set on the same bit in the same cycle.
- **Target selection:** combinational from the `pending` register; result registered into `req_floor`.
  - If the bit for `current_floor` is pending, target = `current_floor`.
  - Otherwise, target = nearest pending floor in the preferred direction.
  - If there is none in that direction, the preference flips and target = nearest pending floor in the new direction.
  - If nothing is pending, target = `current_floor`, so the controller holds position.
- **Direction preference:**
  - Set to UP when `motor_dir` = 01 and to DOWN when `motor_dir` = 10.
  - Otherwise changes only through the flip rule above.
- **FSM:**
  - IDLE: goes to SERVE when `pending` != 000.
  - SERVE: goes to DOOR_WAIT when `door` = 1 and `current_floor` = target.
  - DOOR_WAIT: counter increments each cycle `door` = 1.
    - When the counter reaches `DOOR_CYCLES`, `timer_expired` pulses for one cycle and the counter returns to 0.
    - If `door` stays high, the pulse repeats every `DOOR_CYCLES` cycles.
    - On `door` = 0 the counter clears; next state is SERVE if `pending` != 000, else IDLE.
- **Invalid `current_floor` (3):**
  - `req_floor` holds its value, no clear happens and the counter holds.
  - Call latching continues.
- **Reset mid-operation:** all pending calls are discarded, even with the door open; any in-flight `timer_expired` pulse is suppressed.

## Timing
- Press on `call_btn` at edge n gives `pending` set at n+1, `req_floor` updated at n+2 and `busy` high at n+1.
- `door` rises at edge d, with the FSM entering DOOR_WAIT at d+1.
  - The served `pending` bit clears at d+1.
  - `timer_expired` is high for exactly one cycle, d+`DOOR_CYCLES` to d+`DOOR_CYCLES`+1.
- A `door` fall before the count completes produces no pulse.
- `req_floor` changes at most once per cycle and never shows 000 or more than one bit set, including immediately after reset.
- `timer_expired` never stays high for two consecutive cycles.

## Test plan
1. **Reset values:** hold `reset` for 2 cycles, then release with all inputs 0 and `current_floor` = 0.
   - Expect `req_floor` = 001, `pending` = 000, `busy` = 0, `timer_expired` = 0 for 10 cycles.
2. **Single call:** at floor 0, pulse `call_btn` = 100 for one cycle.
   - Expect `pending` = 100 at +1 and `req_floor` = 100 at +2.
   - Then drive `current_floor` = 2, `door` = 1 for 6 cycles with `DOOR_CYCLES` = 4.
   - Expect `pending` = 000 one cycle after `door` rises, and a `timer_expired` pulse 4 cycles after `door` rises.
3. **Sweep order:** at floor 1, preference UP, with `call_btn` = 101 in one cycle.
   - Expect `req_floor` = 100 first.
   - After floor 2 is served, expect `req_floor` = 001 and the preference flipped to DOWN.
4. **Same-floor press:** at floor 1 with `door` = 1, press `call_btn` = 010.
   - Expect `pending` to stay 000 and no extra `timer_expired` pulse beyond the normal cadence.
5. **Door held open and door closed early:**
   - Hold `door` = 1 for 9 cycles with `DOOR_CYCLES` = 4: expect pulses at +4 and +8.
   - Drop `door` after 2 cycles: expect no pulse and a return to SERVE or IDLE.
6. **Reset mid-operation:** assert `reset` while `pending` = 110 and `door` = 1.
   - Expect `pending` = 000, `req_floor` = 001 and no `timer_expired` pulse after the reset edge.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls, picks one target floor with a direction-preferred sweep,
// and times the door-open interval for the elevator controller.
module elevator_call_scheduler #(
    parameter int DOOR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] call_btn,
    input  logic [1:0] current_floor,
    input  logic [1:0] motor_dir,
    input  logic       door,
    output logic [2:0] req_floor,
    output logic       timer_expired,
    output logic [2:0] pending,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SERVE, DOOR_WAIT} state_t;

    localparam logic [7:0] DOOR_LIMIT = 8'(DOOR_CYCLES);

    state_t     state;
    logic       pref_up;
    logic [7:0] door_cnt;

    logic       floor_valid;
    logic [2:0] cur_oh;
    logic       up_any, dn_any;
    logic [2:0] up_tgt, dn_tgt;
    logic [2:0] target;
    logic       flip;
    logic       at_target;
    logic       door_serving;
    logic       cnt_done;
    logic [2:0] clear_mask, drop_mask, pending_nxt;

    function automatic logic [2:0] floor_onehot(input logic [1:0] f);
        case (f)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Nearest pending floor above and below the current floor.
    always_comb begin
        up_any = 1'b0;
        dn_any = 1'b0;
        up_tgt = 3'b100;
        dn_tgt = 3'b001;
        case (current_floor)
            2'd0: begin
                up_any = pending[1] | pending[2];
                up_tgt = pending[1] ? 3'b010 : 3'b100;
            end
            2'd1: begin
                up_any = pending[2];
                dn_any = pending[0];
            end
            2'd2: begin
                dn_any = pending[1] | pending[0];
                dn_tgt = pending[1] ? 3'b010 : 3'b001;
            end
            default: begin
                up_any = 1'b0;
                dn_any = 1'b0;
            end
        endcase
    end

    always_comb begin
        floor_valid = (current_floor != 2'd3);
        cur_oh      = floor_onehot(current_floor);
        target      = cur_oh;
        flip        = 1'b0;
        if ((pending & cur_oh) != 3'b000) begin
            target = cur_oh;
        end else if (pref_up) begin
            if (up_any) begin
                target = up_tgt;
            end else if (dn_any) begin
                target = dn_tgt;
                flip   = 1'b1;
            end
        end else begin
            if (dn_any) begin
                target = dn_tgt;
            end else if (up_any) begin
                target = up_tgt;
                flip   = 1'b1;
            end
        end

        // The door counts as serving from the very edge the FSM enters DOOR_WAIT.
        at_target    = floor_valid && (req_floor == cur_oh);
        door_serving = door && floor_valid &&
                       ((state == DOOR_WAIT) || ((state == SERVE) && at_target));
        clear_mask   = door_serving ? cur_oh : 3'b000;
        drop_mask    = (door && floor_valid) ? cur_oh : 3'b000;
        pending_nxt  = (pending | (call_btn & ~drop_mask)) & ~clear_mask;
        cnt_done     = (door_cnt >= (DOOR_LIMIT - 8'd1));
    end

    assign busy = (pending != 3'b000) || (state == DOOR_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pref_up       <= 1'b1;
            door_cnt      <= 8'd0;
            timer_expired <= 1'b0;
            pending       <= 3'b000;
            req_floor     <= 3'b001;
        end else begin
            pending       <= pending_nxt;
            timer_expired <= 1'b0;
            if (floor_valid) begin
                req_floor <= target;
            end

            if (motor_dir == 2'b01) begin
                pref_up <= 1'b1;
            end else if (motor_dir == 2'b10) begin
                pref_up <= 1'b0;
            end else if (floor_valid && flip) begin
                pref_up <= ~pref_up;
            end

            case (state)
                IDLE: begin
                    if (pending != 3'b000) begin
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (door_serving) begin
                        state <= DOOR_WAIT;
                        if (cnt_done) begin
                            door_cnt      <= 8'd0;
                            timer_expired <= ~timer_expired;
                        end else begin
                            door_cnt <= door_cnt + 8'd1;
                        end
                    end
                end
                DOOR_WAIT: begin
                    if (!door) begin
                        door_cnt <= 8'd0;
                        state    <= (pending != 3'b000) ? SERVE : IDLE;
                    end else if (floor_valid) begin
                        // Suppressing back-to-back highs keeps DOOR_CYCLES=1 a pulse train.
                        if (cnt_done) begin
                            door_cnt      <= 8'd0;
                            timer_expired <= ~timer_expired;
                        end else begin
                            door_cnt <= door_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler with hand-computed expectations.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] call_btn;
    logic [1:0] current_floor;
    logic [1:0] motor_dir;
    logic       door;
    logic [2:0] req_floor;
    logic       timer_expired;
    logic [2:0] pending;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    elevator_call_scheduler #(.DOOR_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .call_btn      (call_btn),
        .current_floor (current_floor),
        .motor_dir     (motor_dir),
        .door          (door),
        .req_floor     (req_floor),
        .timer_expired (timer_expired),
        .pending       (pending),
        .busy          (busy)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        call_btn      = 3'b000;
        current_floor = 2'd0;
        motor_dir     = 2'b00;
        door          = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (req_floor !== 3'b001 || pending !== 3'b000 || busy !== 1'b0 || timer_expired !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: req=%b pend=%b busy=%b tmr=%b want 001 000 0 0",
                     req_floor, pending, busy, timer_expired);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            total++;
            if (req_floor !== 3'b001 || pending !== 3'b000 || busy !== 1'b0 || timer_expired !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: req=%b pend=%b busy=%b tmr=%b want 001 000 0 0",
                         i, req_floor, pending, busy, timer_expired);
            end
        end
    endtask

    task automatic test_single_call();
        logic exp_t;
        do_reset();
        call_btn = 3'b100;
        tick(1);
        call_btn = 3'b000;
        total++;
        if (pending !== 3'b100 || busy !== 1'b1 || req_floor !== 3'b001) begin
            bad++;
            $display("FAIL single_latch: pend=%b busy=%b req=%b want 100 1 001", pending, busy, req_floor);
        end
        tick(1);
        total++;
        if (req_floor !== 3'b100) begin
            bad++;
            $display("FAIL single_req: got %b want 100", req_floor);
        end
        current_floor = 2'd2;
        door = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            exp_t = (i == 4);
            total++;
            if (timer_expired !== exp_t || pending !== 3'b000 || busy !== 1'b1) begin
                bad++;
                $display("FAIL single_door[%0d]: tmr=%b pend=%b busy=%b want %b 000 1",
                         i, timer_expired, pending, busy, exp_t);
            end
        end
        door = 1'b0;
        tick(1);
        total++;
        if (busy !== 1'b0 || timer_expired !== 1'b0) begin
            bad++;
            $display("FAIL single_close: busy=%b tmr=%b want 0 0", busy, timer_expired);
        end
    endtask

    task automatic test_sweep();
        do_reset();
        current_floor = 2'd1;
        tick(1);
        total++;
        if (req_floor !== 3'b010) begin
            bad++;
            $display("FAIL sweep_hold: got %b want 010", req_floor);
        end
        call_btn = 3'b101;
        tick(1);
        call_btn = 3'b000;
        tick(1);
        total++;
        if (req_floor !== 3'b100 || pending !== 3'b101) begin
            bad++;
            $display("FAIL sweep_up_first: req=%b pend=%b want 100 101", req_floor, pending);
        end
        current_floor = 2'd2;
        door = 1'b1;
        tick(1);
        total++;
        if (pending !== 3'b001) begin
            bad++;
            $display("FAIL sweep_clear2: got %b want 001", pending);
        end
        tick(1);
        total++;
        if (req_floor !== 3'b001) begin
            bad++;
            $display("FAIL sweep_reverse: got %b want 001", req_floor);
        end
        door = 1'b0;
        tick(1);
        current_floor = 2'd1;
        call_btn = 3'b100;
        tick(1);
        call_btn = 3'b000;
        tick(1);
        total++;
        if (req_floor !== 3'b001 || pending !== 3'b101) begin
            bad++;
            $display("FAIL sweep_pref_down: req=%b pend=%b want 001 101", req_floor, pending);
        end
    endtask

    task automatic test_same_floor();
        logic exp_t;
        do_reset();
        current_floor = 2'd1;
        door = 1'b1;
        call_btn = 3'b010;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            total++;
            if (pending !== 3'b000 || timer_expired !== 1'b0) begin
                bad++;
                $display("FAIL same_idle[%0d]: pend=%b tmr=%b want 000 0", i, pending, timer_expired);
            end
        end
        door = 1'b0;
        tick(1);
        call_btn = 3'b000;
        tick(1);
        total++;
        if (pending !== 3'b010 || req_floor !== 3'b010) begin
            bad++;
            $display("FAIL same_latch: pend=%b req=%b want 010 010", pending, req_floor);
        end
        door = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            if (i == 1) call_btn = 3'b010;
            exp_t = (i == 4);
            total++;
            if (pending !== 3'b000 || timer_expired !== exp_t) begin
                bad++;
                $display("FAIL same_door[%0d]: pend=%b tmr=%b want 000 %b", i, pending, timer_expired, exp_t);
            end
        end
        door = 1'b0;
        call_btn = 3'b000;
        tick(1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL same_close: busy=%b want 0", busy);
        end
    endtask

    task automatic test_door_held();
        logic exp_t;
        do_reset();
        call_btn = 3'b001;
        tick(1);
        call_btn = 3'b000;
        tick(1);
        door = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            exp_t = (i % 4 == 0);
            total++;
            if (timer_expired !== exp_t) begin
                bad++;
                $display("FAIL held_pulse[%0d]: got %b want %b", i, timer_expired, exp_t);
            end
        end
        door = 1'b0;
        tick(1);
        total++;
        if (busy !== 1'b0 || timer_expired !== 1'b0) begin
            bad++;
            $display("FAIL held_close: busy=%b tmr=%b want 0 0", busy, timer_expired);
        end
    endtask

    task automatic test_door_early();
        logic exp_t;
        do_reset();
        call_btn = 3'b001;
        tick(1);
        call_btn = 3'b000;
        tick(1);
        door = 1'b1;
        tick(1);
        call_btn = 3'b100;
        tick(1);
        call_btn = 3'b000;
        door = 1'b0;
        tick(1);
        total++;
        if (busy !== 1'b1 || timer_expired !== 1'b0 || req_floor !== 3'b100 || pending !== 3'b100) begin
            bad++;
            $display("FAIL early_close: busy=%b tmr=%b req=%b pend=%b want 1 0 100 100",
                     busy, timer_expired, req_floor, pending);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1);
            total++;
            if (timer_expired !== 1'b0) begin
                bad++;
                $display("FAIL early_nopulse[%0d]: got %b want 0", i, timer_expired);
            end
        end
        current_floor = 2'd2;
        door = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            exp_t = (i == 4);
            total++;
            if (timer_expired !== exp_t) begin
                bad++;
                $display("FAIL early_recount[%0d]: got %b want %b", i, timer_expired, exp_t);
            end
        end
        door = 1'b0;
        tick(1);
    endtask

    task automatic test_invalid_floor();
        do_reset();
        current_floor = 2'd1;
        tick(1);
        current_floor = 2'd3;
        call_btn = 3'b100;
        tick(1);
        call_btn = 3'b000;
        tick(2);
        total++;
        if (req_floor !== 3'b010 || pending !== 3'b100) begin
            bad++;
            $display("FAIL invalid_hold: req=%b pend=%b want 010 100", req_floor, pending);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        call_btn = 3'b111;
        tick(1);
        call_btn = 3'b000;
        tick(1);
        door = 1'b1;
        tick(3);
        total++;
        if (pending !== 3'b110) begin
            bad++;
            $display("FAIL mid_setup: pend=%b want 110", pending);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        total++;
        if (pending !== 3'b000 || req_floor !== 3'b001 || timer_expired !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: pend=%b req=%b tmr=%b busy=%b want 000 001 0 0",
                     pending, req_floor, timer_expired, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            total++;
            if (timer_expired !== 1'b0 || pending !== 3'b000) begin
                bad++;
                $display("FAIL mid_after[%0d]: tmr=%b pend=%b want 0 000", i, timer_expired, pending);
            end
        end
        door = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_call();
        test_sweep();
        test_same_floor();
        test_door_held();
        test_door_early();
        test_invalid_floor();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
